// File: rtl/vector_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vector_ctrl_pkg
// Purpose : Shared definitions for the vector merge arbiter: default widths,
//           opcode encodings, FSM state encoding and requester ids.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package vector_ctrl_pkg;

    localparam int A_W_DEF = 8;
    localparam int B_W_DEF = 7;
    localparam int D_W_DEF = 8;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_LO   = 2'b01;
    localparam logic [1:0] OP_HI   = 2'b10;
    localparam logic [1:0] OP_CAT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter2
// Purpose : Two-way round-robin arbiter. On a tie the requester that was not
//           granted last wins; a lone request always wins.
// Ports   : clk, rst       - clock, synchronous active-high reset
//           req[1:0]       - bit 0 = requester A, bit 1 = requester B
//           update         - commit the current grant into the history
//           grant[1:0]     - one-hot grant (combinational)
//           last_grant     - 1 when B was granted last
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant,
    output logic       last_grant
);

    logic r_last_b;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = r_last_b ? 2'b01 : 2'b10;
        end
    end

    // Reset to "B granted last" so A wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_b <= 1'b1;
        end else if (update && (req != 2'b00)) begin
            r_last_b <= grant[1];
        end
    end

    assign last_grant = r_last_b;

endmodule
`default_nettype wire

// File: rtl/vector_merge_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : vector_merge_arbiter
// Purpose : Two requesters share one result register d. A grant in IDLE
//           latches the winner's opcode/operand; EXEC acknowledges and
//           writes d; DONE is a one-cycle cool-down before the next grant.
// Ports   : clk, rst                  - clock, synchronous active-high reset
//           a_req/a_op/a_data/a_ack   - requester A handshake and operation
//           b_req/b_op/b_data/b_ack   - requester B handshake and operation
//           d                         - shared result register
//           c                         - field view d[3:2]
//           d_upd                     - pulse in the cycle d is written
//           busy                      - high whenever not in IDLE
// Revision: 1.0 - initial release
// ============================================================================
module vector_merge_arbiter
    import vector_ctrl_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int B_W = B_W_DEF,
    parameter int D_W = D_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           a_req,
    input  logic [1:0]     a_op,
    input  logic [A_W-1:0] a_data,
    output logic           a_ack,
    input  logic           b_req,
    input  logic [1:0]     b_op,
    input  logic [B_W-1:0] b_data,
    output logic           b_ack,
    output logic [D_W-1:0] d,
    output logic [1:0]     c,
    output logic           d_upd,
    output logic           busy
);

    state_t         r_state;
    state_t         w_state_next;
    logic           r_src;
    logic [1:0]     r_op;
    logic [D_W-1:0] r_operand;
    logic [D_W-1:0] r_d;
    logic [D_W-1:0] w_d_next;
    logic [3:0]     w_hi;
    logic [1:0]     w_grant;
    logic           w_last_unused;
    logic           w_idle;
    logic           w_exec;

    assign w_idle = (r_state == ST_IDLE);

    rr_arbiter2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        ({b_req, a_req}),
        .update     (w_idle),
        .grant      (w_grant),
        .last_grant (w_last_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (a_req || b_req) w_state_next = ST_EXEC;
            ST_EXEC: w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operands are captured only in the grant cycle; B is zero-extended here
    // so the datapath below sees one common operand format.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src     <= SRC_A;
            r_op      <= OP_LOAD;
            r_operand <= '0;
        end else if (w_idle && (a_req || b_req)) begin
            r_src     <= w_grant[1];
            r_op      <= w_grant[1] ? b_op : a_op;
            r_operand <= w_grant[1] ? D_W'(b_data) : D_W'(a_data);
        end
    end

    // B's high nibble comes from b_data[6:3], which sits at the same bit
    // positions inside the zero-extended operand.
    always_comb begin
        w_hi     = (r_src == SRC_B) ? r_operand[6:3] : r_operand[7:4];
        w_d_next = r_d;
        case (r_op)
            OP_LOAD: w_d_next      = r_operand;
            OP_LO:   w_d_next[3:0] = r_operand[3:0];
            OP_HI:   w_d_next[7:4] = w_hi;
            default: w_d_next[7:0] = {r_operand[3:0], r_d[7:4]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d <= '0;
        end else if (r_state == ST_EXEC) begin
            r_d <= w_d_next;
        end
    end

    // Reset aborts an EXEC in flight, so the strobes are masked by rst.
    assign w_exec = (r_state == ST_EXEC) && !rst;
    assign a_ack  = w_exec && (r_src == SRC_A);
    assign b_ack  = w_exec && (r_src == SRC_B);
    assign d_upd  = w_exec;
    assign busy   = !w_idle && !rst;
    assign d      = r_d;
    assign c      = r_d[3:2];

endmodule
`default_nettype wire

// File: tb/tb_vector_merge_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_vector_merge_arbiter
// Purpose : Self-checking bench: directed vector table, hand-written corner
//           sequences, then randomized traffic against a transaction model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vector_merge_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, b_req;
    logic [1:0] a_op, b_op;
    logic [7:0] a_data;
    logic [6:0] b_data;
    logic       a_ack, b_ack, d_upd, busy;
    logic [7:0] d;
    logic [1:0] c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vector_merge_arbiter #(.A_W(8), .B_W(7), .D_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .a_req  (a_req),
        .a_op   (a_op),
        .a_data (a_data),
        .a_ack  (a_ack),
        .b_req  (b_req),
        .b_op   (b_op),
        .b_data (b_data),
        .b_ack  (b_ack),
        .d      (d),
        .c      (c),
        .d_upd  (d_upd),
        .busy   (busy)
    );

    typedef struct {
        logic       is_b;
        logic [1:0] op;
        logic [7:0] data;
        logic [7:0] exp_d;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; a_req = 0; b_req = 0; a_op = 0; b_op = 0; a_data = 0; b_data = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reference rules for one operation applied to the current d value.
    function automatic logic [7:0] model_op(input logic [7:0] cur, input logic is_b,
                                            input logic [1:0] op, input logic [7:0] ad,
                                            input logic [6:0] bd);
        logic [7:0] opnd;
        logic [3:0] hi;
        opnd = is_b ? {1'b0, bd} : ad;
        hi   = is_b ? bd[6:3] : ad[7:4];
        case (op)
            2'b00:   return opnd;
            2'b01:   return {cur[7:4], opnd[3:0]};
            2'b10:   return {hi, cur[3:0]};
            default: return {opnd[3:0], cur[7:4]};
        endcase
    endfunction

    // One isolated request issued at cycle N from an idle DUT.
    task automatic run_single(input vec_t v, input int idx);
        string n;
        n = $sformatf("vec%0d", idx);
        if (v.is_b) begin b_req = 1; b_op = v.op; b_data = v.data[6:0]; end
        else        begin a_req = 1; a_op = v.op; a_data = v.data;      end
        tick(); // N+1 : EXEC
        chk({n, ".ack"},   v.is_b ? b_ack : a_ack, 1);
        chk({n, ".oack"},  v.is_b ? a_ack : b_ack, 0);
        chk({n, ".d_upd"}, d_upd, 1);
        chk({n, ".busy1"}, busy, 1);
        a_req = 0; b_req = 0;
        a_data = ~a_data; b_data = ~b_data; // late changes must not matter
        tick(); // N+2 : DONE, new d visible
        chk({n, ".d"},      d, v.exp_d);
        chk({n, ".c"},      c, v.exp_d[3:2]);
        chk({n, ".d_upd0"}, d_upd, 0);
        chk({n, ".busy2"},  busy, 1);
        tick(); // N+3 : IDLE
        chk({n, ".busy3"},  busy, 0);
    endtask

    vec_t vecs[10];

    // random-phase model state
    int         t, g;
    logic       m_last_b, pw;
    logic [7:0] md, pd;
    logic       w;

    initial begin
        vecs[0] = '{1'b0, 2'b00, 8'hF5, 8'hF5};
        vecs[1] = '{1'b1, 2'b00, 8'h7F, 8'h7F};
        vecs[2] = '{1'b0, 2'b01, 8'h08, 8'h78};
        vecs[3] = '{1'b1, 2'b10, 8'h7F, 8'hF8};
        vecs[4] = '{1'b0, 2'b11, 8'h3C, 8'hCF};
        vecs[5] = '{1'b1, 2'b01, 8'h25, 8'hC5};
        vecs[6] = '{1'b0, 2'b10, 8'h9A, 8'h95};
        vecs[7] = '{1'b1, 2'b11, 8'h5A, 8'hA9};
        vecs[8] = '{1'b0, 2'b00, 8'h00, 8'h00};
        vecs[9] = '{1'b1, 2'b00, 8'h00, 8'h00};

        // ---- reset state
        do_reset();
        chk("rst.d", d, 8'h00);
        chk("rst.c", c, 2'b00);
        chk("rst.a_ack", a_ack, 0);
        chk("rst.b_ack", b_ack, 0);
        chk("rst.d_upd", d_upd, 0);
        chk("rst.busy", busy, 0);

        // ---- vector table
        for (int i = 0; i < 10; i++) run_single(vecs[i], i);

        // ---- simultaneous requests after reset: A first, then B
        do_reset();
        a_req = 1; a_op = 2'b00; a_data = 8'h0F;
        b_req = 1; b_op = 2'b11; b_data = 7'h7F;
        tick();
        chk("tie.a_ack", a_ack, 1);
        chk("tie.b_ack0", b_ack, 0);
        a_req = 0;
        tick();
        chk("tie.d1", d, 8'h0F);
        chk("tie.b_ack_done", b_ack, 0);
        tick();
        chk("tie.b_ack_idle", b_ack, 0);
        tick();
        chk("tie.b_ack", b_ack, 1);
        b_req = 0;
        tick();
        chk("tie.d2", d, 8'hF0);
        chk("tie.c2", c, 2'b00);
        tick();

        // ---- reset during EXEC aborts the operation
        do_reset();
        a_req = 1; a_op = 2'b00; a_data = 8'hAA;
        tick();
        rst = 1; a_req = 0;
        #1;
        chk("abort.a_ack", a_ack, 0);
        chk("abort.d_upd", d_upd, 0);
        chk("abort.busy", busy, 0);
        tick();
        rst = 0;
        chk("abort.d", d, 8'h00);
        chk("abort.busy_after", busy, 0);
        a_req = 1; a_op = 2'b00; a_data = 8'h11;
        b_req = 1; b_op = 2'b00; b_data = 7'h22;
        tick();
        chk("abort.tie_a", a_ack, 1);
        chk("abort.tie_b", b_ack, 0);
        a_req = 0; b_req = 0;
        tick();
        chk("abort.d2", d, 8'h11);
        tick();

        // ---- A holds req for 6 cycles: grants at N and N+3
        do_reset();
        a_op = 2'b00; a_data = 8'h5C;
        for (int k = 0; k < 8; k++) begin
            a_req = (k < 6);
            #1;
            chk($sformatf("hold.a_ack%0d", k), a_ack, (k == 1 || k == 4) ? 1 : 0);
            chk($sformatf("hold.b_ack%0d", k), b_ack, 0);
            tick();
        end
        chk("hold.d", d, 8'h5C);

        // ---- randomized traffic against a transaction-level model
        do_reset();
        m_last_b = 1'b1; md = 8'h00; pd = 8'h00; pw = 1'b0;
        g = -100;
        for (t = 0; t < 600; t++) begin
            if (t == g + 2) md = pd;
            chk("rnd.a_ack", a_ack, (t == g + 1) && !pw);
            chk("rnd.b_ack", b_ack, (t == g + 1) && pw);
            chk("rnd.d_upd", d_upd, (t == g + 1));
            chk("rnd.busy",  busy,  (t == g + 1) || (t == g + 2));
            chk("rnd.d",     d, md);
            chk("rnd.c",     c, md[3:2]);

            if (a_ack) a_req = ($urandom_range(0, 3) == 0);
            else if (!a_req) a_req = ($urandom_range(0, 2) == 0);
            if (b_ack) b_req = ($urandom_range(0, 3) == 0);
            else if (!b_req) b_req = ($urandom_range(0, 2) == 0);
            a_op = 2'($urandom); a_data = 8'($urandom);
            b_op = 2'($urandom); b_data = 7'($urandom);

            if (t >= g + 3 && (a_req || b_req)) begin
                w = (a_req && b_req) ? !m_last_b : b_req;
                m_last_b = w;
                pd = model_op(md, w, w ? b_op : a_op, a_data, b_data);
                pw = w;
                g  = t;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
